fp_operand_mask: RTL and testbench

- Registered field splitter at the front end of the FP32 adder datapath.
- Accepts two IEEE-754 single-precision operands, A and B, through a valid/ready handshake.
- Presents each operand's sign, biased exponent and stored mantissa one cycle later.
- Also presents the 24-bit significand with the implicit bit restored, plus operand-class flags, to the alignment stage.

---
 rtl/fp32_pkg.sv | 34 +++
 rtl/fp_operand_mask_if.sv | 60 ++++++
 rtl/fp_field_split.sv | 53 +++++
 rtl/fp_operand_mask.sv | 125 ++++++++++++
 tb/tb_fp_operand_mask.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
//------------------------------------------------------------------------------
// Module      : fp32_pkg
// Description : FP32 field widths, field/class types shared by the operand
//               front end of the FP32 adder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fp32_pkg;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int FP_W  = 1 + EXP_W + MAN_W;
   localparam int SIG_W = MAN_W + 1;

   localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exponent;
      logic [MAN_W-1:0] mantissa;
   } fp32_fields_t;

   // One-hot-or-zero operand class; all-zero means a normal number.
   typedef struct packed {
      logic is_nan;
      logic is_inf;
      logic is_denorm;
      logic is_zero;
   } fp_class_t;

endpackage : fp32_pkg

`default_nettype wire

// File: rtl/fp_operand_mask_if.sv
//------------------------------------------------------------------------------
// Module      : fp_operand_mask_if
// Description : Operand handshake and split-field bus of fp_operand_mask.
//               classA/classB exist only when MASK_CLASSIFY_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fp_operand_mask_if
   import fp32_pkg::*;
#(
   parameter int EXP_W = fp32_pkg::EXP_W,
   parameter int MAN_W = fp32_pkg::MAN_W
) ();

   localparam int c_FP_W  = 1 + EXP_W + MAN_W;
   localparam int c_SIG_W = MAN_W + 1;

   logic               in_valid;
   logic               in_ready;
   logic [c_FP_W-1:0]  A;
   logic [c_FP_W-1:0]  B;
   logic               out_valid;
   logic               out_ready;
   logic               signA;
   logic               signB;
   logic [EXP_W-1:0]   exponentA;
   logic [EXP_W-1:0]   exponentB;
   logic [MAN_W-1:0]   mantissaA;
   logic [MAN_W-1:0]   mantissaB;
   logic [c_SIG_W-1:0] sigA;
   logic [c_SIG_W-1:0] sigB;
`ifdef MASK_CLASSIFY_EN
   logic [3:0]         classA;
   logic [3:0]         classB;
`endif

   modport master (
`ifdef MASK_CLASSIFY_EN
      input  classA, classB,
`endif
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid,
      input  signA, signB, exponentA, exponentB,
      input  mantissaA, mantissaB, sigA, sigB
   );

   modport slave (
`ifdef MASK_CLASSIFY_EN
      output classA, classB,
`endif
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid,
      output signA, signB, exponentA, exponentB,
      output mantissaA, mantissaB, sigA, sigB
   );

endinterface : fp_operand_mask_if

`default_nettype wire

// File: rtl/fp_field_split.sv
//------------------------------------------------------------------------------
// Module      : fp_field_split
// Description : Combinational split of one FP operand into sign, exponent,
//               mantissa and hidden-bit significand; class output only with
//               MASK_CLASSIFY_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fp_field_split
   import fp32_pkg::*;
#(
   parameter int EXP_W = fp32_pkg::EXP_W,
   parameter int MAN_W = fp32_pkg::MAN_W
) (
   input  wire logic [EXP_W+MAN_W:0] operand,
   output logic                      sign,
   output logic [EXP_W-1:0]          exponent,
   output logic [MAN_W-1:0]          mantissa,
`ifdef MASK_CLASSIFY_EN
   output fp_class_t                 cls,
`endif
   output logic [MAN_W:0]            sig
);

   localparam int c_FP_W = 1 + EXP_W + MAN_W;

   logic w_exp_zero;

   assign sign       = operand[c_FP_W-1];
   assign exponent   = operand[c_FP_W-2 -: EXP_W];
   assign mantissa   = operand[MAN_W-1:0];
   assign w_exp_zero = (exponent == '0);

   // Denormals and zero carry no implicit leading one.
   assign sig = {~w_exp_zero, mantissa};

`ifdef MASK_CLASSIFY_EN
   logic w_exp_max;
   logic w_man_zero;

   assign w_exp_max  = &exponent;
   assign w_man_zero = (mantissa == '0);

   assign cls.is_zero   = w_exp_zero &  w_man_zero;
   assign cls.is_denorm = w_exp_zero & ~w_man_zero;
   assign cls.is_inf    = w_exp_max  &  w_man_zero;
   assign cls.is_nan    = w_exp_max  & ~w_man_zero;
`endif

endmodule : fp_field_split

`default_nettype wire

// File: rtl/fp_operand_mask.sv
//------------------------------------------------------------------------------
// Module      : fp_operand_mask
// Description : Registered FP operand field splitter, one output stage with
//               valid/ready and full throughput. Optional operand class
//               flags under MASK_CLASSIFY_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fp_operand_mask
   import fp32_pkg::*;
#(
   parameter int EXP_W = fp32_pkg::EXP_W,
   parameter int MAN_W = fp32_pkg::MAN_W
) (
   input wire logic          clk,
   input wire logic          rst_n,
   fp_operand_mask_if.slave  bus
);

   logic             w_accept;
   logic             w_sign_a,     w_sign_b;
   logic [EXP_W-1:0] w_exponent_a, w_exponent_b;
   logic [MAN_W-1:0] w_mantissa_a, w_mantissa_b;
   logic [MAN_W:0]   w_sig_a,      w_sig_b;

   logic             r_out_valid;
   logic             r_sign_a,     r_sign_b;
   logic [EXP_W-1:0] r_exponent_a, r_exponent_b;
   logic [MAN_W-1:0] r_mantissa_a, r_mantissa_b;
   logic [MAN_W:0]   r_sig_a,      r_sig_b;

`ifdef MASK_CLASSIFY_EN
   fp_class_t        w_class_a,    w_class_b;
   fp_class_t        r_class_a,    r_class_b;
`endif

   assign bus.in_ready = ~r_out_valid | bus.out_ready;
   assign w_accept     = bus.in_valid & bus.in_ready;

   fp_field_split #(
      .EXP_W    (EXP_W),
      .MAN_W    (MAN_W)
   ) u_split_a (
      .operand  (bus.A),
      .sign     (w_sign_a),
      .exponent (w_exponent_a),
      .mantissa (w_mantissa_a),
`ifdef MASK_CLASSIFY_EN
      .cls      (w_class_a),
`endif
      .sig      (w_sig_a)
   );

   fp_field_split #(
      .EXP_W    (EXP_W),
      .MAN_W    (MAN_W)
   ) u_split_b (
      .operand  (bus.B),
      .sign     (w_sign_b),
      .exponent (w_exponent_b),
      .mantissa (w_mantissa_b),
`ifdef MASK_CLASSIFY_EN
      .cls      (w_class_b),
`endif
      .sig      (w_sig_b)
   );

   // Fields load only on accept, so idle-cycle X on A/B never reaches them.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_sign_a     <= 1'b0;
         r_sign_b     <= 1'b0;
         r_exponent_a <= '0;
         r_exponent_b <= '0;
         r_mantissa_a <= '0;
         r_mantissa_b <= '0;
         r_sig_a      <= '0;
         r_sig_b      <= '0;
      end else begin
         if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_sign_a     <= w_sign_a;
            r_sign_b     <= w_sign_b;
            r_exponent_a <= w_exponent_a;
            r_exponent_b <= w_exponent_b;
            r_mantissa_a <= w_mantissa_a;
            r_mantissa_b <= w_mantissa_b;
            r_sig_a      <= w_sig_a;
            r_sig_b      <= w_sig_b;
         end else if (bus.out_ready) begin
            r_out_valid  <= 1'b0;
         end
      end
   end

`ifdef MASK_CLASSIFY_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_class_a <= '0;
         r_class_b <= '0;
      end else if (w_accept) begin
         r_class_a <= w_class_a;
         r_class_b <= w_class_b;
      end
   end

   assign bus.classA = r_class_a;
   assign bus.classB = r_class_b;
`endif

   assign bus.out_valid = r_out_valid;
   assign bus.signA     = r_sign_a;
   assign bus.signB     = r_sign_b;
   assign bus.exponentA = r_exponent_a;
   assign bus.exponentB = r_exponent_b;
   assign bus.mantissaA = r_mantissa_a;
   assign bus.mantissaB = r_mantissa_b;
   assign bus.sigA      = r_sig_a;
   assign bus.sigB      = r_sig_b;

endmodule : fp_operand_mask

`default_nettype wire

// File: tb/tb_fp_operand_mask.sv
//------------------------------------------------------------------------------
// Module      : tb_fp_operand_mask
// Description : Directed self-checking bench for fp_operand_mask; class
//               checks are active when MASK_CLASSIFY_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fp_operand_mask;
   import fp32_pkg::*;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   fp_operand_mask_if bus ();

   fp_operand_mask dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b1;
      bus.A         = 32'h4049_0FDB;
      bus.B         = 32'hC000_0001;
      bus.out_ready = 1'b0;
      tick();
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
      checks++; if ({bus.signA, bus.exponentA, bus.mantissaA} !== 32'h0) begin errors++; $display("FAIL reset_fields_a got %h want 0", {bus.signA, bus.exponentA, bus.mantissaA}); end
      checks++; if ({bus.signB, bus.exponentB, bus.mantissaB} !== 32'h0) begin errors++; $display("FAIL reset_fields_b got %h want 0", {bus.signB, bus.exponentB, bus.mantissaB}); end
      checks++; if ({bus.sigA, bus.sigB} !== 48'h0) begin errors++; $display("FAIL reset_sig got %h want 0", {bus.sigA, bus.sigB}); end
`ifdef MASK_CLASSIFY_EN
      checks++; if ({bus.classA, bus.classB} !== 8'h0) begin errors++; $display("FAIL reset_class got %h want 0", {bus.classA, bus.classB}); end
`endif
      rst_n        = 1'b1;
      bus.in_valid = 1'b0;
      tick();
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got %0b want 0", bus.out_valid); end
   endtask

   task automatic test_basic();
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.A         = 32'h3F80_0000;
      bus.B         = 32'hC049_0FDB;
      tick();
      bus.in_valid  = 1'b0;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", bus.out_valid); end
      checks++; if (bus.signA !== 1'b0) begin errors++; $display("FAIL basic_signA got %0b want 0", bus.signA); end
      checks++; if (bus.exponentA !== 8'h7F) begin errors++; $display("FAIL basic_exponentA got %h want 7f", bus.exponentA); end
      checks++; if (bus.mantissaA !== 23'h0) begin errors++; $display("FAIL basic_mantissaA got %h want 0", bus.mantissaA); end
      checks++; if (bus.sigA !== 24'h80_0000) begin errors++; $display("FAIL basic_sigA got %h want 800000", bus.sigA); end
      checks++; if (bus.signB !== 1'b1) begin errors++; $display("FAIL basic_signB got %0b want 1", bus.signB); end
      checks++; if (bus.exponentB !== 8'h80) begin errors++; $display("FAIL basic_exponentB got %h want 80", bus.exponentB); end
      checks++; if (bus.mantissaB !== 23'h49_0FDB) begin errors++; $display("FAIL basic_mantissaB got %h want 490fdb", bus.mantissaB); end
      checks++; if (bus.sigB !== 24'hC9_0FDB) begin errors++; $display("FAIL basic_sigB got %h want c90fdb", bus.sigB); end
`ifdef MASK_CLASSIFY_EN
      checks++; if ({bus.classA, bus.classB} !== 8'h00) begin errors++; $display("FAIL basic_class got %h want 00", {bus.classA, bus.classB}); end
`endif
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %0b want 0", bus.out_valid); end
   endtask

   task automatic test_classes();
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.A         = 32'h7F80_0000;
      bus.B         = 32'h7FC0_0000;
      tick();
      checks++; if (bus.sigA !== 24'h80_0000) begin errors++; $display("FAIL inf_sigA got %h want 800000", bus.sigA); end
      checks++; if (bus.sigB !== 24'hC0_0000) begin errors++; $display("FAIL nan_sigB got %h want c00000", bus.sigB); end
`ifdef MASK_CLASSIFY_EN
      checks++; if (bus.classA !== 4'b0100) begin errors++; $display("FAIL inf_classA got %b want 0100", bus.classA); end
      checks++; if (bus.classB !== 4'b1000) begin errors++; $display("FAIL nan_classB got %b want 1000", bus.classB); end
`endif
      bus.A = 32'h0000_0001;
      bus.B = 32'h8000_0000;
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL class_b2b_valid got %0b want 1", bus.out_valid); end
      checks++; if (bus.sigA !== 24'h00_0001) begin errors++; $display("FAIL denorm_sigA got %h want 000001", bus.sigA); end
      checks++; if (bus.exponentA !== 8'h00) begin errors++; $display("FAIL denorm_exponentA got %h want 00", bus.exponentA); end
      checks++; if (bus.signB !== 1'b1) begin errors++; $display("FAIL zero_signB got %0b want 1", bus.signB); end
      checks++; if (bus.sigB !== 24'h0) begin errors++; $display("FAIL zero_sigB got %h want 0", bus.sigB); end
`ifdef MASK_CLASSIFY_EN
      checks++; if (bus.classA !== 4'b0010) begin errors++; $display("FAIL denorm_classA got %b want 0010", bus.classA); end
      checks++; if (bus.classB !== 4'b0001) begin errors++; $display("FAIL zero_classB got %b want 0001", bus.classB); end
`endif
      tick();
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.A         = 32'h1234_5678;
      bus.B         = 32'h4000_0000;
      tick();
      // Next pair waits at the input while the first is held.
      bus.A = 32'hDEAD_BEEF;
      bus.B = 32'h0080_0000;
      for (int i = 0; i < 3; i++) begin
         checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %0b want 0", i, bus.in_ready); end
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %0b want 1", i, bus.out_valid); end
         checks++; if (bus.exponentA !== 8'h24) begin errors++; $display("FAIL bp_exponentA[%0d] got %h want 24", i, bus.exponentA); end
         checks++; if (bus.mantissaA !== 23'h34_5678) begin errors++; $display("FAIL bp_mantissaA[%0d] got %h want 345678", i, bus.mantissaA); end
         checks++; if (bus.exponentB !== 8'h80) begin errors++; $display("FAIL bp_exponentB[%0d] got %h want 80", i, bus.exponentB); end
         tick();
      end
      bus.out_ready = 1'b1;
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b want 1", bus.in_ready); end
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_no_bubble got %0b want 1", bus.out_valid); end
      checks++; if ({bus.signA, bus.exponentA, bus.mantissaA} !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp_next_A got %h want deadbeef", {bus.signA, bus.exponentA, bus.mantissaA}); end
      checks++; if (bus.sigB !== 24'h80_0000) begin errors++; $display("FAIL bp_next_sigB got %h want 800000", bus.sigB); end
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", bus.out_valid); end
   endtask

   task automatic test_stream();
      logic [31:0]  ea, eb;
      fp32_fields_t fa, fb;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         ea    = $urandom;
         eb    = $urandom;
         bus.A = ea;
         bus.B = eb;
         fa    = ea;
         fb    = eb;
         tick();
         checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b want 1", i, bus.out_valid); end
         checks++; if ({bus.signA, bus.exponentA, bus.mantissaA} !== ea) begin errors++; $display("FAIL stream_A[%0d] got %h want %h", i, {bus.signA, bus.exponentA, bus.mantissaA}, ea); end
         checks++; if ({bus.signB, bus.exponentB, bus.mantissaB} !== eb) begin errors++; $display("FAIL stream_B[%0d] got %h want %h", i, {bus.signB, bus.exponentB, bus.mantissaB}, eb); end
         checks++; if (bus.sigA !== {fa.exponent != 8'h00, fa.mantissa}) begin errors++; $display("FAIL stream_sigA[%0d] got %h want %h", i, bus.sigA, {fa.exponent != 8'h00, fa.mantissa}); end
         checks++; if (bus.sigB !== {fb.exponent != 8'h00, fb.mantissa}) begin errors++; $display("FAIL stream_sigB[%0d] got %h want %h", i, bus.sigB, {fb.exponent != 8'h00, fb.mantissa}); end
      end
      // Idle cycle with undriven operands must leave the last result intact.
      bus.in_valid = 1'b0;
      bus.A        = 'x;
      bus.B        = 'x;
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %0b want 0", bus.out_valid); end
      checks++; if ({bus.signA, bus.exponentA, bus.mantissaA} !== ea) begin errors++; $display("FAIL idle_hold_A got %h want %h", {bus.signA, bus.exponentA, bus.mantissaA}, ea); end
      checks++; if (bus.sigB !== {fb.exponent != 8'h00, fb.mantissa}) begin errors++; $display("FAIL idle_hold_sigB got %h want %h", bus.sigB, {fb.exponent != 8'h00, fb.mantissa}); end
   endtask

   task automatic test_reset_mid();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.A         = 32'h4049_0FDB;
      bus.B         = 32'h3F80_0000;
      tick();
      bus.in_valid  = 1'b0;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rmid_loaded got %0b want 1", bus.out_valid); end
      rst_n = 1'b0;
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %0b want 0", bus.out_valid); end
      checks++; if ({bus.signA, bus.exponentA, bus.mantissaA, bus.sigB} !== 56'h0) begin errors++; $display("FAIL rmid_fields got %h want 0", {bus.signA, bus.exponentA, bus.mantissaA, bus.sigB}); end
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmid_lost got %0b want 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %0b want 1", bus.in_ready); end
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      test_reset();
      test_basic();
      test_classes();
      test_backpressure();
      test_stream();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_fp_operand_mask

`default_nettype wire
